// File: rtl/i2s_pkg.sv
// Shared I2S constants and types used by the clock generator, the receiver
// and the transmitter side (speaker_control).
//   I2S_DATA_W     : sample width in bits
//   I2S_CNT_W      : width of the free-running frame counter (512 clk / frame)
//   SLOT_LEFT_LSB  : bit slot carrying left[0]
//   SLOT_RIGHT_LSB : bit slot carrying right[0] (one-bit I2S delay)
//   SAMPLE_PHASE   : cnt[3:0] value at which serial data is sampled (SCLK rise)
package i2s_pkg;

  localparam int I2S_DATA_W     = 16;
  localparam int I2S_CNT_W      = 9;
  localparam int SLOT_LEFT_LSB  = 16;
  localparam int SLOT_RIGHT_LSB = 0;
  localparam int SAMPLE_PHASE   = 7;

  typedef logic [I2S_DATA_W-1:0] sample_t;
  typedef logic [I2S_CNT_W-1:0]  cnt_t;

  // Counter value of the mid-bit sampling edge for a given bit slot.
  function automatic cnt_t strobe_cnt(input int slot);
    return cnt_t'(slot * 16 + SAMPLE_PHASE);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S clock generator: a 9-bit free-running counter from which MCLK (clk/4),
// SCLK (clk/16) and LRCK (clk/512) are taken directly. Shared with
// speaker_control so transmit and receive bit slots line up after a common
// reset.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   cnt_o    : current counter value (bit slot = cnt_o[8:4])
//   mclk_o   : master clock, cnt[1]
//   sck_o    : serial bit clock, cnt[3]
//   lrck_o   : word select, cnt[8] (0 = left, 1 = right)
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output cnt_t cnt_o,
  output logic mclk_o,
  output logic sck_o,
  output logic lrck_o
);

  cnt_t cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o  = cnt_q;
  assign mclk_o = cnt_q[1];
  assign sck_o  = cnt_q[3];
  assign lrck_o = cnt_q[I2S_CNT_W-1];

endmodule

// File: rtl/i2s_audio_receiver.sv
// Master-mode I2S receiver. Generates MCLK/SCLK/LRCK, synchronises the ADC
// serial data, deserialises 16-bit left/right samples and presents each
// complete stereo frame with a one-cycle valid strobe.
// Ports:
//   clk, rst        : 100 MHz system clock, asynchronous active-high reset
//   audio_mclk      : clk/4 master clock
//   audio_lrck      : clk/512 word select (0 = left, 1 = right)
//   audio_sck       : clk/16 serial bit clock
//   audio_sdout     : serial data from the ADC (changes after SCLK fall)
//   audio_out_left  : last complete left sample
//   audio_out_right : last complete right sample
//   audio_valid     : one-cycle pulse when both samples update
// Parameter SYNC_STAGES (2..4): synchroniser depth on audio_sdout.
module i2s_audio_receiver
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst,
  output logic    audio_mclk,
  output logic    audio_lrck,
  output logic    audio_sck,
  input  logic    audio_sdout,
  output sample_t audio_out_left,
  output sample_t audio_out_right,
  output logic    audio_valid
);

  localparam logic [3:0] PHASE     = 4'(SAMPLE_PHASE);
  localparam logic [4:0] SLOT_LEFT = 5'(SLOT_LEFT_LSB);
  localparam logic [4:0] SLOT_RGHT = 5'(SLOT_RIGHT_LSB);

  cnt_t cnt;

  i2s_clk_gen u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .cnt_o  (cnt),
    .mclk_o (audio_mclk),
    .sck_o  (audio_sck),
    .lrck_o (audio_lrck)
  );

  // Data synchroniser chain.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sd_s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= audio_sdout;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign sd_s = sync_q[SYNC_STAGES-1];

  // Sampling at mid-bit: the synchroniser delay (<= 4) plus ADC tco settle
  // well before phase 7, so the sample point does not move with SYNC_STAGES.
  logic    strobe;
  logic    slot_left_end;
  logic    slot_right_end;
  sample_t shifted;

  assign strobe         = (cnt[3:0] == PHASE);
  assign slot_left_end  = strobe && (cnt[8:4] == SLOT_LEFT);
  assign slot_right_end = strobe && (cnt[8:4] == SLOT_RGHT);

  sample_t sr_q, sr_d;
  sample_t left_hold_q, left_hold_d;
  sample_t out_left_q, out_left_d;
  sample_t out_right_q, out_right_d;
  logic    primed_q, primed_d;
  logic    valid_q, valid_d;

  assign shifted = {sr_q[I2S_DATA_W-2:0], sd_s};

  always_comb begin
    sr_d        = sr_q;
    left_hold_d = left_hold_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    primed_d    = primed_q;
    valid_d     = 1'b0;

    if (strobe) sr_d = shifted;

    if (slot_left_end) begin
      left_hold_d = shifted;
      primed_d    = 1'b1;
    end

    // Right LSB arrives in slot 0 of the following frame; without a captured
    // left word (first partial frame after reset) the frame is dropped.
    if (slot_right_end && primed_q) begin
      out_right_d = shifted;
      out_left_d  = left_hold_q;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      primed_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      primed_q    <= primed_d;
      valid_q     <= valid_d;
    end
  end

  assign audio_out_left  = out_left_q;
  assign audio_out_right = out_right_q;
  assign audio_valid     = valid_q;

endmodule

// File: doc/i2s_audio_receiver.md
# i2s_audio_receiver

Master-mode I2S receiver for the stereo ADC on the audio Pmod. It generates MCLK, LRCK and SCLK from the system clock using the same divider ratios as `speaker_control`. It deserialises the ADC's serial data into 16-bit left/right samples and presents each complete stereo frame with a one-cycle valid strobe. It sits between the Pmod line-in pins and the recording/effects datapath.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `audio_sdout`. Legal range 2–4.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `audio_mclk` output 1: master clock, clk/4.
- `audio_lrck` output 1: word select, clk/512. 0 = left, 1 = right.
- `audio_sck` output 1: serial bit clock, clk/16 (32 bits per frame).
- `audio_sdout` input 1: serial data from the ADC. It changes after each SCLK falling edge.
- `audio_out_left` output 16: last complete left sample, two's complement.
- `audio_out_right` output 16: last complete right sample, two's complement.
- `audio_valid` output 1: one-cycle pulse when both outputs update.

## Operation
- 9-bit free-running counter `cnt` on `clk`; it wraps 511→0.
- Clock outputs:
  - `audio_mclk` = `cnt[1]`
  - `audio_sck` = `cnt[3]`
  - `audio_lrck` = `cnt[8]`
- Bit slot = `cnt[8:4]` (0–31), using standard I2S one-bit delay after each LRCK edge:
  - slot 0 carries right[0] of the previous frame.
  - slots 1–16 carry left[15:0], MSB first.
  - slots 17–31 carry right[15:1].
- `audio_sdout` passes through the SYNC_STAGES synchroniser to give `sd_s`.
- Sample strobe fires on the clk edge where `cnt[3:0]` == 7, i.e. mid-bit, at the edge that raises SCLK.
  - On each strobe: `sr <= {sr[14:0], sd_s}`, a 16-bit shift register.
- Strobe in slot 16 (`cnt` == 263):
  - `left_hold <= {sr[14:0], sd_s}`
  - set `primed`
- Strobe in slot 0 (`cnt` == 7), if `primed`:
  - `audio_out_right <= {sr[14:0], sd_s}`
  - `audio_out_left <= left_hold`
  - `audio_valid <= 1`
- If `primed` is clear at the slot 0 strobe: no update and no pulse. This discards the partial frame that follows reset.
- `audio_valid` is cleared on every other cycle.
- Output samples hold their value until the next valid pulse.
- There is no backpressure. The consumer must accept the data within 512 cycles.
- Reset, asynchronous and usable mid-operation:
  - `cnt`, `sr`, `left_hold`, synchroniser flops, `primed`, `audio_out_*` and `audio_valid` all go to 0.
  - `audio_mclk`, `audio_sck` and `audio_lrck` therefore read 0.
  - A frame in progress is discarded, and the full priming sequence restarts after release.

## Timing
- Cycle 0 = first clk edge after `rst` deasserts (`cnt` becomes 1).
- The first `audio_valid` is high during the cycle after the edge where `cnt` goes 7 of frame 1, i.e. 519 edges after release.
- Thereafter `audio_valid` repeats exactly every 512 cycles, one cycle wide.
- Latency from the LSB of the right channel being driven (slot 0 SCLK fall) to the valid pulse is 8 clk.
- The synchroniser delay of SYNC_STAGES ≤ 4 plus ADC tco must stay below 7 clk. The sample point is fixed at `cnt[3:0]` == 7 regardless of SYNC_STAGES.
- LRCK, SCLK and MCLK are phase-identical to `speaker_control` after a common reset. A shared-reset loopback therefore lines up bit slots exactly.

## Structure
- Shared package `i2s_pkg`:
  - `I2S_DATA_W` = 16
  - `I2S_CNT_W` = 9
  - slot constants `SLOT_LEFT_LSB` = 16 and `SLOT_RIGHT_LSB` = 0
  - `SAMPLE_PHASE` = 7
- One sub-module, `i2s_clk_gen`: the counter plus MCLK/SCLK/LRCK assigns, exporting `cnt`. It is reused by a refactored `speaker_control`.
- The synchroniser, shift register, capture logic and `primed` flag stay in `i2s_audio_receiver`.

## Test plan
- Reset held, then released:
  - All outputs are 0 during reset.
  - `audio_valid` stays 0 for edges 1–518 and pulses at edge 519.
  - The first samples are from the first full frame only.
- ADC BFM drives left = 16'hA5C3, right = 16'h3C5A, MSB first, with one-bit delay, changing on SCLK fall:
  - Expect `audio_out_left` = A5C3 and `audio_out_right` = 3C5A at the first valid pulse.
- Consecutive frames (1111/2222, 8000/0001, FFFF/0000):
  - Valid period is exactly 512 cycles.
  - Outputs change only coincident with the valid pulse.
  - The 8000/0001 frame confirms bit order and the slot-0 LSB.
- `rst` asserted at `cnt` = 300 mid-frame:
  - Outputs clear immediately.
  - The next valid arrives 519 edges after release, carrying the new frame's data.
- Loopback `speaker_control` → receiver on a shared `clk`/`rst`, with left = 16'h7FFF, right = 16'h8001 (transmitter-side inputs):
  - The receiver outputs match from the second frame on.
- Repeat the A5C3/3C5A case with SYNC_STAGES = 4:
  - Identical results and identical valid timing.
